// File: rtl/axil_mem_responder.sv
// AXI4-Lite memory responder: word-addressed RAM with byte strobes,
// independent read/write channels and a configurable read wait-state.
module axil_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 1
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // ---------------- write channel ----------------
  w_state_t          w_state, w_state_d;
  logic              aw_got, w_got;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs, w_hs, wr_commit, wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [IDX_W-1:0]  wr_idx;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  // The last of AW/W to arrive is used straight off the bus so the commit
  // happens on its handshake edge.
  assign wr_addr     = aw_got ? awaddr_q : awaddr;
  assign wr_data     = w_got  ? wdata_q  : wdata;
  assign wr_strb     = w_got  ? wstrb_q  : wstrb;
  assign wr_idx      = wr_addr[ADDR_W-1:2];
  assign wr_in_range = wr_idx < IDX_W'(DEPTH_WORDS);
  assign wr_commit   = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (!nreset) w_state <= W_IDLE;
    else         w_state <= w_state_d;
  end

  // Write FSM next state
  always_comb begin
    w_state_d = w_state;
    case (w_state)
      W_IDLE:  if (wr_commit) w_state_d = W_RESP;
      W_RESP:  if (bready)    w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel handshakes, capture flags and B response registers
  always_ff @(posedge clk) begin
    if (!nreset) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_in_range ? OKAY : SLVERR;
          end else begin
            if (aw_hs) begin
              aw_got   <= 1'b1;
              awaddr_q <= awaddr;
              awready  <= 1'b0;
            end else if (!aw_got) begin
              awready  <= 1'b1;
            end
            if (w_hs) begin
              w_got   <= 1'b1;
              wdata_q <= wdata;
              wstrb_q <= wstrb;
              wready  <= 1'b0;
            end else if (!w_got) begin
              wready  <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-lane memory update; a reset edge never commits
  always_ff @(posedge clk) begin
    if (nreset && wr_commit && wr_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem[wr_idx[MEM_AW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state, r_state_d;
  logic [ADDR_W-1:0] araddr_q, rd_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic [3:0]        rd_cnt;
  logic              ar_hs, rd_sample, rd_in_range;

  assign ar_hs       = arvalid & arready;
  assign rd_addr     = (r_state == R_IDLE) ? araddr : araddr_q;
  assign rd_idx      = rd_addr[ADDR_W-1:2];
  assign rd_in_range = rd_idx < IDX_W'(DEPTH_WORDS);
  // Array is sampled on the edge that enters R_DATA
  assign rd_sample   = ((r_state == R_IDLE) && ar_hs && (RD_LATENCY == 0)) ||
                       ((r_state == R_WAIT) && (rd_cnt == 4'd0));

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!nreset) r_state <= R_IDLE;
    else         r_state <= r_state_d;
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_d = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (rd_cnt == 4'd0) r_state_d = R_DATA;
      R_DATA:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // AR capture, wait-state counter and R response registers
  always_ff @(posedge clk) begin
    if (!nreset) begin
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= OKAY;
      araddr_q <= '0;
      rd_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready  <= 1'b0;
            araddr_q <= araddr;
            rd_cnt   <= 4'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
          end else begin
            arready  <= 1'b1;
          end
        end
        R_WAIT: if (rd_cnt != 4'd0) rd_cnt <= rd_cnt - 4'd1;
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: ;
      endcase
      if (rd_sample) begin
        rvalid <= 1'b1;
        rdata  <= rd_in_range ? mem[rd_idx[MEM_AW-1:0]] : '0;
        rresp  <= rd_in_range ? OKAY : SLVERR;
      end
    end
  end

  // Byte-offset bits carry no meaning for a word-addressed memory
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

endmodule

// File: doc/axil_mem_responder.md
Name: axil_mem_responder

Overview:
- AXI4-Lite slave (responder) backing the user-data side of the aximem bus; the memory end that the CPU's umem/axim master path talks to.
- Word-addressed RAM with byte strobes, independent read and write channels, and a configurable read wait-state for exercising master stall handling.
- Instantiated in the top-level bench/SoC opposite the CPU's aximem master port.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width (fixed 32; strobe width DATA_W/8)
DEPTH_WORDS, 1024, number of 32-bit words backed
RD_LATENCY, 1, extra wait cycles between AR handshake and RVALID (0..15)

Ports:
clk  in  1  clock
nreset  in  1  reset, synchronous, active-low
awaddr  in  ADDR_W  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte-lane enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response (00 OKAY, 10 SLVERR)
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_W  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_W  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset (nreset=0 at posedge): all outputs 0 (readies, valids, resp, rdata); both FSMs to IDLE; captured-flag registers cleared. Memory array NOT cleared; simulation initialises it to 0. Reset mid-transaction abandons it; a write not yet committed is never performed.
- All outputs registered. Readies rise the first cycle after nreset deasserts.
- Address decode: word index = addr[ADDR_W-1:2]; addr[1:0] ignored. Index >= DEPTH_WORDS is out of range.
- Write FSM, W_IDLE -> W_RESP -> W_IDLE:
  - In W_IDLE, awready=1 until AW captured; wready=1 until W captured. AW and W are accepted independently, in either order or the same cycle.
  - Each channel deasserts its ready the cycle after its handshake and holds its captured value.
  - When both are captured, move to W_RESP. On that edge, commit the write per wstrb lane (lane i writes bits 8i+7:8i) and drive bvalid=1.
  - bresp=OKAY if in range. If out of range, bresp=SLVERR and memory is unchanged.
  - wstrb=0 gives OKAY with no change.
  - bvalid and bresp are held stable until bready=1. The cycle after the B handshake: bvalid=0, return to W_IDLE, readies reassert.
- Read FSM, R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
  - arready=1 in R_IDLE; AR handshake latches the address and drops arready.
  - R_WAIT counts RD_LATENCY cycles. With RD_LATENCY=0, R_WAIT is skipped, so rvalid is asserted the cycle after the AR handshake; in general the latency is RD_LATENCY+1 cycles.
  - On entry to R_DATA, rdata is registered from the array: out-of-range gives rdata=0 and rresp=SLVERR, otherwise OKAY.
  - rvalid, rdata and rresp are held stable until rready. The cycle after the R handshake: rvalid=0, arready=1.
- Channels are fully independent; one outstanding transaction per direction. A write committing on the same edge the read samples the array is not visible to that read (old data returned).
- Valid outputs never depend combinationally on ready inputs.

Test Plan:
- Write then read: AW=0x10, W=0xDEADBEEF, wstrb=F, same cycle -> bvalid the next cycle with OKAY. Then AR=0x10 with RD_LATENCY=1 -> rvalid 2 cycles after AR handshake, rdata=0xDEADBEEF.
- Byte strobes: preload 0x11223344 at 0x20, write 0xAABBCCDD with wstrb=0101 -> read returns 0x11BB33DD.
- Channel ordering: W presented 3 cycles before AW at 0x8; awaddr=0x8 arrives -> wready drops after the W handshake, bvalid only after AW is accepted. Repeat with AW first. Both cases store the data.
- Backpressure: bready=0 for 5 cycles, then rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata/rresp held constant; no second AW/AR is accepted until the response handshake completes.
- Out of range: DEPTH_WORDS=1024, write 0x1000 -> SLVERR with memory unchanged (probe 0x0). Read 0x1000 -> rdata=0, rresp=SLVERR.
- Reset mid-op: assert nreset=0 after AW is captured but before W arrives -> all outputs 0. After release, readies go to 1 and no write occurs; a read of that address returns its prior value.
